// File: rtl/overlap_accum_seq_if.sv
// Term/result handshake bundle for overlap_accum_seq: serial term input,
// next-term index and the held overlap-add result.
interface overlap_accum_seq_if #(
  parameter int W   = 163,
  parameter int OFS = 82,
  parameter int K   = 3
);
  localparam int RW = (K - 1) * OFS + W;
  localparam int IW = $clog2(K);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [IW-1:0] term_idx;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, term_idx, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, term_idx, out_valid, out_data
  );
endinterface

// File: rtl/overlap_accum_seq.sv
// Serial overlap-add: K terms arrive one per accept and are XOR-accumulated
// at offsets k*OFS into a RW-bit result held on a valid/ready output.
module overlap_accum_seq #(
  parameter int W   = 163,
  parameter int OFS = 82,
  parameter int K   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  overlap_accum_seq_if.slave bus
);
  localparam int RW = (K - 1) * OFS + W;
  localparam int IW = $clog2(K);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state;
  logic [RW-1:0] acc;
  logic [RW-1:0] ext;
  logic [RW-1:0] shifted;

  assign ext          = RW'(bus.in_data);
  assign bus.out_data = acc;

  // Constant-shift mux keyed on the term index keeps every shift static.
  always_comb begin
    shifted = '0;
    for (int unsigned k = 0; k < K; k++) begin
      if (bus.term_idx == IW'(k)) shifted = ext << (k * OFS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.term_idx  <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      bus.term_idx  <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Term 0 overwrites so no earlier result can leak into this one.
            acc          <= ext;
            bus.term_idx <= IW'(1);
            state        <= ACC;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc <= acc ^ shifted;
            if (bus.term_idx == IW'(K - 1)) begin
              bus.term_idx  <= '0;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              bus.term_idx <= bus.term_idx + IW'(1);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.term_idx  <= '0;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_overlap_accum_seq.sv
// Directed bench for overlap_accum_seq at default parameters plus a small
// W=8/OFS=4/K=4 instance.
module tb_overlap_accum_seq;
  localparam int W   = 163;
  localparam int OFS = 82;
  localparam int K   = 3;
  localparam int RW  = (K - 1) * OFS + W;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush_b;
  int   checks;
  int   passed;

  logic [RW-1:0] exp_basic;
  logic [RW-1:0] exp_ones;

  overlap_accum_seq_if #(.W(W), .OFS(OFS), .K(K)) bus_a ();
  overlap_accum_seq_if #(.W(8), .OFS(4), .K(4))   bus_b ();

  overlap_accum_seq #(.W(W), .OFS(OFS), .K(K)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a)
  );
  overlap_accum_seq #(.W(8), .OFS(4), .K(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [W-1:0] d);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
  endtask

  task automatic send_b(input logic [7:0] d);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    tick();
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = '0;
  endtask

  task automatic release_a();
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus_a.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus_a.in_ready); else passed++;
    checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus_a.out_valid); else passed++;
    checks++; if (bus_a.term_idx !== 2'd0) $display("FAIL reset_term_idx got %0d exp 0", bus_a.term_idx); else passed++;
    checks++; if (bus_a.out_data !== '0) $display("FAIL reset_out_data got %h exp 0", bus_a.out_data); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus_a.out_ready = 1'b1;
    send_a(1);
    checks++; if (bus_a.term_idx !== 2'd1) $display("FAIL basic_idx1 got %0d exp 1", bus_a.term_idx); else passed++;
    checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", bus_a.out_valid); else passed++;
    send_a(1);
    checks++; if (bus_a.term_idx !== 2'd2) $display("FAIL basic_idx2 got %0d exp 2", bus_a.term_idx); else passed++;
    send_a(1);
    checks++; if (bus_a.out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", bus_a.out_valid); else passed++;
    checks++; if (bus_a.in_ready !== 1'b0) $display("FAIL basic_in_ready_done got %b exp 0", bus_a.in_ready); else passed++;
    checks++; if (bus_a.term_idx !== 2'd0) $display("FAIL basic_idx_wrap got %0d exp 0", bus_a.term_idx); else passed++;
    checks++; if (bus_a.out_data !== exp_basic) $display("FAIL basic_data got %h exp %h", bus_a.out_data, exp_basic); else passed++;
    tick();
    checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle got %b exp 0", bus_a.out_valid); else passed++;
    checks++; if (bus_a.in_ready !== 1'b1) $display("FAIL basic_in_ready_idle got %b exp 1", bus_a.in_ready); else passed++;
    bus_a.out_ready = 1'b0;
  endtask

  task automatic test_cancel();
    logic [W-1:0] t;
    t = '0;
    t[82] = 1'b1;
    send_a(t);
    send_a(1);
    send_a(0);
    checks++; if (bus_a.out_valid !== 1'b1) $display("FAIL cancel_valid got %b exp 1", bus_a.out_valid); else passed++;
    checks++; if (bus_a.out_data !== '0) $display("FAIL cancel_zero got %h exp 0", bus_a.out_data); else passed++;
    release_a();
    send_a('1);
    send_a('1);
    send_a('1);
    checks++; if (bus_a.out_data !== exp_ones) $display("FAIL cancel_ones got %h exp %h", bus_a.out_data, exp_ones); else passed++;
    release_a();
  endtask

  task automatic test_backpressure();
    send_a(1);
    send_a(1);
    send_a(1);
    for (int i = 0; i < 5; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = W'(i * 7 + 3);
      tick();
      checks++; if (bus_a.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus_a.in_ready); else passed++;
      checks++; if (bus_a.out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b exp 1", i, bus_a.out_valid); else passed++;
      checks++; if (bus_a.term_idx !== 2'd0) $display("FAIL bp_term_idx[%0d] got %0d exp 0", i, bus_a.term_idx); else passed++;
      checks++; if (bus_a.out_data !== exp_basic) $display("FAIL bp_data[%0d] got %h exp %h", i, bus_a.out_data, exp_basic); else passed++;
    end
    bus_a.in_data   = W'(2);
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    checks++; if (bus_a.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", bus_a.in_ready); else passed++;
    checks++; if (bus_a.term_idx !== 2'd0) $display("FAIL bp_release_idx got %0d exp 0", bus_a.term_idx); else passed++;
    tick();
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.term_idx !== 2'd1) $display("FAIL bp_term0_accept got %0d exp 1", bus_a.term_idx); else passed++;
    send_a(0);
    send_a(0);
    checks++; if (bus_a.out_data !== RW'(2)) $display("FAIL bp_next_result got %h exp 2", bus_a.out_data); else passed++;
    release_a();
  endtask

  task automatic test_gaps();
    logic [5:0] pat;
    logic [1:0] exp_idx [6];
    pat = 6'b101001;
    exp_idx = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    for (int i = 0; i < 6; i++) begin
      bus_a.in_valid = pat[i];
      bus_a.in_data  = pat[i] ? W'(1) : W'('h5a5);
      tick();
      checks++; if (bus_a.term_idx !== exp_idx[i]) $display("FAIL gaps_idx[%0d] got %0d exp %0d", i, bus_a.term_idx, exp_idx[i]); else passed++;
    end
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b1) $display("FAIL gaps_valid got %b exp 1", bus_a.out_valid); else passed++;
    checks++; if (bus_a.out_data !== exp_basic) $display("FAIL gaps_data got %h exp %h", bus_a.out_data, exp_basic); else passed++;
    release_a();
  endtask

  task automatic test_flush();
    send_a(7);
    send_a(9);
    checks++; if (bus_a.term_idx !== 2'd2) $display("FAIL flush_pre_idx got %0d exp 2", bus_a.term_idx); else passed++;
    flush = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = W'(3);
    tick();
    flush = 1'b0;
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.term_idx !== 2'd0) $display("FAIL flush_idx got %0d exp 0", bus_a.term_idx); else passed++;
    checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", bus_a.out_valid); else passed++;
    checks++; if (bus_a.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", bus_a.in_ready); else passed++;
    checks++; if (bus_a.out_data !== '0) $display("FAIL flush_acc_clear got %h exp 0", bus_a.out_data); else passed++;
    send_a(5);
    send_a(0);
    send_a(0);
    checks++; if (bus_a.out_data !== RW'(5)) $display("FAIL flush_next_data got %h exp 5", bus_a.out_data); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL flush_done_valid got %b exp 0", bus_a.out_valid); else passed++;
    checks++; if (bus_a.out_data !== '0) $display("FAIL flush_done_data got %h exp 0", bus_a.out_data); else passed++;
  endtask

  task automatic test_reset_mid();
    send_a(7);
    send_a(9);
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.term_idx !== 2'd0) $display("FAIL rst_mid_idx got %0d exp 0", bus_a.term_idx); else passed++;
    checks++; if (bus_a.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b exp 1", bus_a.in_ready); else passed++;
    checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", bus_a.out_valid); else passed++;
    checks++; if (bus_a.out_data !== '0) $display("FAIL rst_mid_data got %h exp 0", bus_a.out_data); else passed++;
    tick();
    rst_n = 1'b1;
    send_a(5);
    send_a(0);
    send_a(0);
    checks++; if (bus_a.out_valid !== 1'b1) $display("FAIL rst_next_valid got %b exp 1", bus_a.out_valid); else passed++;
    checks++; if (bus_a.out_data !== RW'(5)) $display("FAIL rst_next_data got %h exp 5", bus_a.out_data); else passed++;
    release_a();
  endtask

  task automatic test_param_sweep();
    logic [1:0] exp_idx [4];
    exp_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send_b(8'hFF);
      checks++; if (bus_b.term_idx !== exp_idx[i]) $display("FAIL sweep_idx[%0d] got %0d exp %0d", i, bus_b.term_idx, exp_idx[i]); else passed++;
    end
    checks++; if (bus_b.out_valid !== 1'b1) $display("FAIL sweep_valid got %b exp 1", bus_b.out_valid); else passed++;
    checks++; if (bus_b.out_data !== 20'hF000F) $display("FAIL sweep_data got %h exp f000f", bus_b.out_data); else passed++;
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    checks++; if (bus_b.out_valid !== 1'b0) $display("FAIL sweep_release got %b exp 0", bus_b.out_valid); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    flush_b = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_data = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data = '0;
    bus_b.out_ready = 1'b0;

    exp_basic = '0;
    exp_basic[0] = 1'b1;
    exp_basic[82] = 1'b1;
    exp_basic[164] = 1'b1;
    for (int b = 0; b < RW; b++) exp_ones[b] = (b < 82) || (b == 163) || (b >= 245);

    test_reset();
    test_basic();
    test_cancel();
    test_backpressure();
    test_gaps();
    test_flush();
    test_reset_mid();
    test_param_sweep();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
